uds_loader: RTL and testbench
=============================

// Module: uds_loader
// PURPOSE
//  One-shot boot loader for the UDS store. After reset it fetches NUM_WORDS
//  32-bit words from the word-addressed secret ROM (NVCM port) and writes
//  them into the uds core's UDS register bank through a write port.
//  The transfer runs once per reset. The loader then locks, so firmware can
//  never re-trigger it or observe the words in flight.
// PARAMETERS
//  NUM_WORDS  8      UDS words to transfer (1..8; uds_waddr is 3 bits)
//  ROM_BASE   8'h00  ROM word address of UDS word 0
//  TIMEOUT    255    max cycles waiting for rom_ack per word (1..255)
// PORTS
//  clk          in   1   system clock
//  reset        in   1   asynchronous, active-high reset
//  fw_app_mode  in   1   1 = application mode; aborts an unfinished load
//  rom_req      out  1   read request to the secret ROM
//  rom_addr     out  8   ROM word address
//  rom_ack      in   1   1-cycle strobe; rom_rdata valid in that cycle
//  rom_rdata    in   32  ROM read data
//  uds_we       out  1   1-cycle write strobe into the UDS bank
//  uds_waddr    out  3   UDS word index
//  uds_wdata    out  32  UDS word
//  busy         out  1   load in progress
//  done         out  1   sticky: all words written, check passed
//  error        out  1   sticky: timeout, abort or check fail
// BEHAVIOUR
//  Reset: every output is 0, state IDLE, word counter idx=0, timer=0.
//   Reset mid-load drops to IDLE at once. The load then restarts from word 0.
//  FSM: IDLE -> REQ -> WAIT -> WRITE -> (REQ | CHECK | DONE); any -> ERROR.
//   IDLE : leave on the first clk edge after reset deasserts. busy=1 from
//          that edge on.
//   REQ  : rom_req=1, rom_addr=ROM_BASE+idx (8-bit wrap), timer=0. Go to WAIT.
//   WAIT : rom_req stays 1 and rom_addr stays stable until ack. On rom_ack,
//          latch rom_rdata and go to WRITE. timer increments each WAIT cycle.
//          If timer==TIMEOUT with no ack, go to ERROR.
//   WRITE: uds_we=1 for exactly 1 cycle, uds_waddr=idx, uds_wdata=latched word.
//          If idx==NUM_WORDS-1, go to CHECK (macro set) or DONE.
//          Otherwise idx++ and go to REQ.
//   DONE / ERROR: terminal until reset. busy=0. rom_req=0. uds_we never pulses.
//   uds_wdata is 0 in every cycle except WRITE. The data latch clears in
//   DONE/ERROR.
//  Latency: per word = 1 (REQ) + ack delay + 1 (WRITE). With 1-cycle ack,
//   8 words finish in 24 cycles after IDLE.
//  rom_ack outside WAIT is ignored.
//  fw_app_mode=1 in any state other than DONE/ERROR: go to ERROR next cycle,
//   and no further uds_we. This takes priority over a simultaneous rom_ack.
//  done and error are never both 1.
// CONFIGURATION
//  UDS_LOADER_CHECK_EN defined:
//   - An XOR accumulator runs over all loaded words.
//   - CHECK state fetches one extra word at ROM_BASE+NUM_WORDS using the same
//     REQ/WAIT handshake and timeout. This word is not written to the bank.
//   - Match: go to DONE. Mismatch: NUM_WORDS writes of 32'h0 (idx 0..N-1, one
//     per cycle) scrub the bank, then ERROR.
//  Not defined: no CHECK state. WRITE of the last word goes straight to DONE.
// TESTING
//  1 Nominal: ROM words 0x11111111*k, 1-cycle ack -> 8 uds_we pulses, waddr
//    0..7, correct data, done=1 at cycle 24, busy=0, error=0.
//  2 Timeout: no rom_ack on word 3 -> error=1 after 255 WAIT cycles; exactly 3
//    uds_we pulses seen; rom_req=0 afterwards.
//  3 Abort: fw_app_mode=1 in the same cycle as rom_ack for word 5 -> no write
//    of word 5, error=1 next cycle, done=0.
//  4 Reset mid-load: reset pulse during WAIT of word 4 -> outputs 0 at once;
//    after release the load restarts at rom_addr=ROM_BASE and completes.
//  5 CHECK_EN pass: check word = XOR of 8 words -> done=1 with 9 ROM reads.
//    Fail: check word off by 1 bit -> 8 zero writes, then error=1.
//  6 Stray ack / lock: rom_ack pulses in IDLE and in DONE -> no state change
//    and no uds_we.

Source files
------------

// File: rtl/uds_loader_if.sv
// uds_loader_if
//   Bundles the loader's ROM read port, UDS bank write port, firmware mode
//   input and status outputs.
//   master : the loader (drives rom_req/rom_addr, uds_*, busy/done/error)
//   slave  : the ROM / bank / firmware side
interface uds_loader_if;
  logic        fw_app_mode;
  logic        rom_req;
  logic [7:0]  rom_addr;
  logic        rom_ack;
  logic [31:0] rom_rdata;
  logic        uds_we;
  logic [2:0]  uds_waddr;
  logic [31:0] uds_wdata;
  logic        busy;
  logic        done;
  logic        error;

  modport master (
    input  fw_app_mode, rom_ack, rom_rdata,
    output rom_req, rom_addr, uds_we, uds_waddr, uds_wdata, busy, done, error
  );

  modport slave (
    output fw_app_mode, rom_ack, rom_rdata,
    input  rom_req, rom_addr, uds_we, uds_waddr, uds_wdata, busy, done, error
  );
endinterface

// File: rtl/uds_loader.sv
// uds_loader
//   One-shot boot loader: after reset, reads NUM_WORDS words from the secret
//   ROM starting at ROM_BASE and writes them into the UDS register bank, then
//   locks in DONE or ERROR until the next reset.
// Ports
//   clk    : system clock
//   reset  : asynchronous, active-high reset
//   bus    : uds_loader_if.master (ROM read port, UDS write port,
//            fw_app_mode abort input, busy/done/error status)
// Configuration
//   UDS_LOADER_CHECK_EN : when defined, an XOR of all loaded words is compared
//   against one extra ROM word at ROM_BASE+NUM_WORDS; on mismatch the bank is
//   scrubbed with zeros and the loader ends in ERROR.
module uds_loader #(
  parameter int         NUM_WORDS = 8,
  parameter logic [7:0] ROM_BASE  = 8'h00,
  parameter int         TIMEOUT   = 255
) (
  input  logic          clk,
  input  logic          reset,
  uds_loader_if.master  bus
);

  typedef enum logic [3:0] {
    IDLE, REQ, WAIT, WRITE, CHECK, CHK_WAIT, SCRUB, DONE, ERROR
  } state_e;

  localparam logic [2:0] LAST_IDX = 3'(NUM_WORDS - 1);
  // WAIT gives up once TIMEOUT cycles have passed without an ack
  localparam logic [7:0] TMO_LAST = 8'(TIMEOUT - 1);
  localparam logic [7:0] CHK_ADDR = ROM_BASE + 8'(NUM_WORDS);

  state_e      state_q, state_d;
  logic [2:0]  idx_q,   idx_d;
  logic [7:0]  timer_q, timer_d;
  logic [31:0] data_q,  data_d;
`ifdef UDS_LOADER_CHECK_EN
  logic [31:0] acc_q,   acc_d;
`endif

  logic        rom_req_o;
  logic [7:0]  rom_addr_o;
  logic        uds_we_o;
  logic [2:0]  uds_waddr_o;
  logic [31:0] uds_wdata_o;
  logic        busy_o, done_o, error_o;
  logic [7:0]  word_addr;

  assign word_addr = ROM_BASE + {5'd0, idx_q};

  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    timer_d     = timer_q;
    data_d      = data_q;
`ifdef UDS_LOADER_CHECK_EN
    acc_d       = acc_q;
`endif
    rom_req_o   = 1'b0;
    rom_addr_o  = 8'h00;
    uds_we_o    = 1'b0;
    uds_waddr_o = 3'd0;
    uds_wdata_o = 32'h0;
    busy_o      = 1'b0;
    done_o      = 1'b0;
    error_o     = 1'b0;

    case (state_q)
      IDLE: state_d = REQ;
      REQ: begin
        busy_o     = 1'b1;
        rom_req_o  = 1'b1;
        rom_addr_o = word_addr;
        timer_d    = 8'd0;
        state_d    = WAIT;
      end
      WAIT: begin
        busy_o     = 1'b1;
        rom_req_o  = 1'b1;
        rom_addr_o = word_addr;
        timer_d    = timer_q + 8'd1;
        if (bus.rom_ack) begin
          data_d  = bus.rom_rdata;
          state_d = WRITE;
        end else if (timer_q == TMO_LAST) begin
          state_d = ERROR;
        end
      end
      WRITE: begin
        busy_o      = 1'b1;
        uds_we_o    = 1'b1;
        uds_waddr_o = idx_q;
        uds_wdata_o = data_q;
`ifdef UDS_LOADER_CHECK_EN
        acc_d       = acc_q ^ data_q;
`endif
        if (idx_q == LAST_IDX) begin
`ifdef UDS_LOADER_CHECK_EN
          state_d = CHECK;
`else
          state_d = DONE;
`endif
        end else begin
          idx_d   = idx_q + 3'd1;
          state_d = REQ;
        end
      end
`ifdef UDS_LOADER_CHECK_EN
      CHECK: begin
        busy_o     = 1'b1;
        rom_req_o  = 1'b1;
        rom_addr_o = CHK_ADDR;
        timer_d    = 8'd0;
        state_d    = CHK_WAIT;
      end
      CHK_WAIT: begin
        busy_o     = 1'b1;
        rom_req_o  = 1'b1;
        rom_addr_o = CHK_ADDR;
        timer_d    = timer_q + 8'd1;
        if (bus.rom_ack) begin
          if (bus.rom_rdata == acc_q) begin
            state_d = DONE;
          end else begin
            idx_d   = 3'd0;
            state_d = SCRUB;
          end
        end else if (timer_q == TMO_LAST) begin
          state_d = ERROR;
        end
      end
      // Zero every bank word so a corrupted image is never left in place
      SCRUB: begin
        busy_o      = 1'b1;
        uds_we_o    = 1'b1;
        uds_waddr_o = idx_q;
        if (idx_q == LAST_IDX) state_d = ERROR;
        else                   idx_d   = idx_q + 3'd1;
      end
`endif
      DONE:    done_o  = 1'b1;
      ERROR:   error_o = 1'b1;
      default: state_d = ERROR;
    endcase

    // Firmware leaving boot mode kills an unfinished load, even over an ack
    if (bus.fw_app_mode && state_q != DONE && state_q != ERROR)
      state_d = ERROR;

    // Never keep a secret word around once the loader has locked
    if (state_d == DONE || state_d == ERROR)
      data_d = 32'h0;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      idx_q   <= 3'd0;
      timer_q <= 8'd0;
      data_q  <= 32'h0;
`ifdef UDS_LOADER_CHECK_EN
      acc_q   <= 32'h0;
`endif
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      timer_q <= timer_d;
      data_q  <= data_d;
`ifdef UDS_LOADER_CHECK_EN
      acc_q   <= acc_d;
`endif
    end
  end

  assign bus.rom_req   = rom_req_o;
  assign bus.rom_addr  = rom_addr_o;
  assign bus.uds_we    = uds_we_o;
  assign bus.uds_waddr = uds_waddr_o;
  assign bus.uds_wdata = uds_wdata_o;
  assign bus.busy      = busy_o;
  assign bus.done      = done_o;
  assign bus.error     = error_o;

endmodule

// File: tb/tb_uds_loader.sv
// tb_uds_loader
//   Randomized bench for uds_loader. A ROM responder with random ack delays
//   and stray acks drives the DUT; expected writes, request addresses and
//   completion times are derived from the load rules (per word: one request
//   cycle, ack delay, one write cycle) using the delays the bench chose.
module tb_uds_loader;
  localparam int         N    = 8;
  localparam logic [7:0] BASE = 8'hFA;  // forces the 8-bit address wrap
`ifdef UDS_LOADER_CHECK_EN
  localparam int CHK = 1;
`else
  localparam int CHK = 0;
`endif

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  uds_loader_if bus ();

  uds_loader #(.NUM_WORDS(N), .ROM_BASE(BASE), .TIMEOUT(255)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.master)
  );

  int n_cmp = 0;
  int n_err = 0;

  logic [31:0] rom [256];
  int          dly_q[$];
  logic [7:0]  raddr_q[$];
  logic [2:0]  wa_q[$];
  logic [31:0] wd_q[$];
  int          t_end;
  int          fixed_dly;
  bit          addr_unstable, wdata_leak;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [47:0] outs();
    return {bus.rom_req, bus.rom_addr, bus.uds_we, bus.uds_waddr, bus.uds_wdata,
            bus.busy, bus.done, bus.error};
  endfunction

  function automatic logic [31:0] xor_words();
    logic [31:0] x = 32'h0;
    for (int k = 0; k < N; k++) x ^= rom[8'(BASE + k)];
    return x;
  endfunction

  task automatic fill_rom(input bit nominal);
    for (int a = 0; a < 256; a++) rom[a] = $urandom;
    for (int k = 0; k < N; k++) rom[8'(BASE + k)] = nominal ? 32'h11111111 * k : $urandom;
    rom[8'(BASE + N)] = xor_words();
  endtask

  // Cycles from the first busy cycle until the word-th request is raised
  function automatic int t_words(input int n);
    int s = 0;
    if (dly_q.size() < n) return -1;
    for (int k = 0; k < n; k++) s += 2 + dly_q[k];
    return s;
  endfunction

  task automatic do_reset();
    reset = 1'b1;
    bus.fw_app_mode = 1'b0;
    bus.rom_ack = 1'b0;
    bus.rom_rdata = 32'h0;
    repeat (2) @(negedge clk);
  endtask

  // Release reset with a stray ack that lands while the loader is in IDLE
  task automatic release_reset();
    @(negedge clk);
    reset = 1'b0;
    bus.rom_ack = 1'b1;
    bus.rom_rdata = $urandom;
  endtask

  task automatic run(input int hang_w, input int abort_w, input int stop_w, input int budget);
    int hi = 0, d = 1, t0 = -1, nreq = 0;
    logic [7:0] a0 = 8'h00;
    dly_q.delete(); raddr_q.delete(); wa_q.delete(); wd_q.delete();
    t_end = -1; addr_unstable = 0; wdata_leak = 0;
    for (int c = 0; c < budget; c++) begin
      @(negedge clk);
      if (bus.busy && t0 < 0) t0 = c;
      if (bus.uds_we) begin
        wa_q.push_back(bus.uds_waddr);
        wd_q.push_back(bus.uds_wdata);
      end else if (bus.uds_wdata != 32'h0) begin
        wdata_leak = 1;
      end
      bus.rom_ack = 1'b0;
      bus.fw_app_mode = 1'b0;
      if (bus.done || bus.error) begin
        if (t0 >= 0) t_end = c - t0;
        break;
      end
      if (bus.rom_req) begin
        hi++;
        if (hi == 1) begin
          a0 = bus.rom_addr;
          raddr_q.push_back(a0);
          d = (fixed_dly != 0) ? fixed_dly : int'($urandom_range(1, 4));
          dly_q.push_back(d);
          nreq++;
        end else if (bus.rom_addr != a0) begin
          addr_unstable = 1;
        end
        if (hi == 1 + d && nreq - 1 != hang_w) begin
          bus.rom_ack = 1'b1;
          bus.rom_rdata = rom[a0];
          if (nreq - 1 == abort_w) bus.fw_app_mode = 1'b1;
        end
        if (nreq - 1 == stop_w && hi == 3) break;
      end else begin
        hi = 0;
        bus.rom_ack = ($urandom_range(0, 2) == 0);
        bus.rom_rdata = $urandom;
      end
    end
  endtask

  task automatic check_writes(input string tag, input int n_data, input bit scrub);
    int n_exp = n_data + (scrub ? N : 0);
    chk({tag, "_wr_cnt"}, wa_q.size(), n_exp);
    for (int i = 0; i < wa_q.size() && i < n_exp; i++) begin
      if (i < n_data) begin
        chk({tag, "_wr_addr"}, wa_q[i], i);
        chk({tag, "_wr_data"}, wd_q[i], rom[8'(BASE + i)]);
      end else begin
        chk({tag, "_scrub_addr"}, wa_q[i], i - n_data);
        chk({tag, "_scrub_data"}, wd_q[i], 0);
      end
    end
    chk({tag, "_leak"}, wdata_leak, 0);
    chk({tag, "_addr_stable"}, addr_unstable, 0);
  endtask

  task automatic check_reqs(input string tag, input int n_exp);
    chk({tag, "_req_cnt"}, raddr_q.size(), n_exp);
    for (int i = 0; i < raddr_q.size() && i < n_exp; i++)
      chk({tag, "_req_addr"}, raddr_q[i], 8'(BASE + i));
  endtask

  // After locking: stray acks and app mode must change nothing
  task automatic post_lock(input string tag, input bit exp_done);
    int bad = 0;
    for (int c = 0; c < 20; c++) begin
      bus.rom_ack = $urandom_range(0, 1);
      bus.fw_app_mode = $urandom_range(0, 1);
      bus.rom_rdata = $urandom;
      @(negedge clk);
      if (bus.uds_we || bus.rom_req || bus.busy || bus.uds_wdata != 0 ||
          bus.done != exp_done || bus.error != !exp_done) bad++;
    end
    bus.rom_ack = 1'b0;
    bus.fw_app_mode = 1'b0;
    chk({tag, "_lock"}, bad, 0);
  endtask

  initial begin
    int exp_t;
    fixed_dly = 0;
    do_reset();
    chk("rst_outs", outs(), 0);
    bus.rom_ack = 1'b1;
    @(negedge clk);
    chk("rst_stray_ack", outs(), 0);

    // Nominal: 0x11111111*k, 1-cycle ack
    fill_rom(1);
    fixed_dly = 1;
    release_reset();
    run(-1, -1, -1, 400);
    check_writes("nom", N, 0);
    check_reqs("nom", N + CHK);
    chk("nom_t", t_end, CHK ? 26 : 24);
    post_lock("nom", 1);
    fixed_dly = 0;

    // Random data and ack delays
    for (int it = 0; it < 4; it++) begin
      do_reset();
      fill_rom(0);
      release_reset();
      run(-1, -1, -1, 400);
      check_writes("rnd", N, 0);
      check_reqs("rnd", N + CHK);
      exp_t = (dly_q.size() > N * CHK) ? t_words(N) + CHK * (1 + dly_q[N * CHK]) : -2;
      chk("rnd_t", t_end, exp_t);
      chk("rnd_done", {bus.done, bus.error, bus.busy}, 3'b100);
    end

    // Timeout on word 3
    do_reset();
    fill_rom(0);
    release_reset();
    run(3, -1, -1, 800);
    check_writes("tmo", 3, 0);
    check_reqs("tmo", 4);
    chk("tmo_t", t_end, t_words(3) + 256);
    post_lock("tmo", 0);

    // Abort with fw_app_mode alongside the ack of word 5
    do_reset();
    fill_rom(0);
    release_reset();
    run(-1, 5, -1, 400);
    check_writes("abt", 5, 0);
    exp_t = (dly_q.size() > 5) ? t_words(5) + 1 + dly_q[5] : -2;
    chk("abt_t", t_end, exp_t);
    post_lock("abt", 0);

    // Reset in the WAIT of word 4, then a full reload
    do_reset();
    fill_rom(0);
    release_reset();
    run(4, -1, 4, 400);
    chk("mid_reached", raddr_q.size(), 5);
    #2 reset = 1'b1;
    #1 chk("mid_rst_outs", outs(), 0);
    @(negedge clk);
    chk("mid_rst_hold", outs(), 0);
    release_reset();
    run(-1, -1, -1, 400);
    check_writes("rld", N, 0);
    check_reqs("rld", N + CHK);
    chk("rld_done", {bus.done, bus.error}, 2'b10);

`ifdef UDS_LOADER_CHECK_EN
    // Check word off by one bit: scrub then error
    do_reset();
    fill_rom(0);
    rom[8'(BASE + N)] ^= 32'h1 << $urandom_range(0, 31);
    release_reset();
    run(-1, -1, -1, 400);
    check_writes("cfail", N, 1);
    check_reqs("cfail", N + 1);
    exp_t = (dly_q.size() > N) ? t_words(N) + 1 + dly_q[N] + N : -2;
    chk("cfail_t", t_end, exp_t);
    post_lock("cfail", 0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
